// File: rtl/stack_dbg_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stack_dbg_arbiter_if: debug command/response channel of the stack arbiter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface stack_dbg_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/stack_dbg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stack_dbg_arbiter: muxes core and debug-host ops onto one stack, tracks    |
// | occupancy and sticky overflow/underflow. Revision: 1.0                     |
// +----------------------------------------------------------------------------+
module stack_dbg_arbiter #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 18,
  localparam int CAP   = DEPTH + 1,
  localparam int DW    = $clog2(CAP + 1)
) (
  input  wire logic             clk,
  input  wire logic             resetq,
  input  wire logic             core_we,
  input  wire logic [1:0]       core_delta,
  input  wire logic [WIDTH-1:0] core_wd,
  output logic                  st_we,
  output logic      [1:0]       st_delta,
  output logic      [WIDTH-1:0] st_wd,
  input  wire logic [WIDTH-1:0] st_rd,
  output logic                  halt,
  stack_dbg_arbiter_if.slave    dbg,
  output logic      [DW-1:0]    depth,
  output logic                  ovf,
  output logic                  unf,
  input  wire logic             flag_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0]    OP_PEEK  = 2'b00;
  localparam logic [1:0]    OP_PUSH  = 2'b01;
  localparam logic [1:0]    OP_DEPTH = 2'b10;
  localparam logic [1:0]    OP_POP   = 2'b11;
  localparam logic [DW-1:0] C_FULL   = DW'(CAP);

  state_t           r_state, w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic             w_core_active, w_issue, w_refuse;
  logic             w_dbg_push, w_dbg_pop, w_push, w_pop;
  logic [WIDTH-1:0] w_rsp_data;

  assign w_core_active = core_we | core_delta[0];
  assign w_issue       = (r_state == S_WAIT) && !w_core_active;
  assign w_refuse      = ((r_op == OP_PUSH) && (depth == C_FULL)) ||
                         ((r_op == OP_POP)  && (depth == '0));
  assign w_dbg_push    = w_issue && !w_refuse && (r_op == OP_PUSH);
  assign w_dbg_pop     = w_issue && !w_refuse && (r_op == OP_POP);
  assign w_push        = (core_delta == 2'b01) || w_dbg_push;
  assign w_pop         = (core_delta == 2'b11) || w_dbg_pop;

  // Core always wins the stack port; debug only drives it in its issue cycle.
  always_comb begin
    st_we    = 1'b0;
    st_delta = 2'b00;
    st_wd    = '0;
    if (w_core_active) begin
      st_we    = core_we;
      st_delta = core_delta;
      st_wd    = core_wd;
    end else if (w_dbg_push) begin
      st_we    = 1'b1;
      st_delta = 2'b01;
      st_wd    = r_data;
    end else if (w_dbg_pop) begin
      st_delta = 2'b11;
    end
  end

  always_comb begin
    w_rsp_data = '0;
    if (!w_refuse) begin
      case (r_op)
        OP_PUSH:  w_rsp_data = r_data;
        OP_DEPTH: w_rsp_data = WIDTH'(depth);
        default:  w_rsp_data = st_rd;
      endcase
    end
  end

  always_comb begin
    w_next        = r_state;
    halt          = 1'b0;
    dbg.cmd_ready = 1'b0;
    dbg.rsp_valid = 1'b0;
    dbg.rsp_data  = r_rsp_data;
    dbg.rsp_err   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        dbg.cmd_ready = 1'b1;
        if (dbg.cmd_valid) w_next = S_WAIT;
      end
      S_WAIT: begin
        halt = 1'b1;
        if (w_issue) w_next = S_RESP;
      end
      S_RESP: begin
        dbg.rsp_valid = 1'b1;
        if (dbg.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state    <= S_IDLE;
      r_op       <= OP_PEEK;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      depth      <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && dbg.cmd_valid) begin
        r_op   <= dbg.cmd_op;
        r_data <= dbg.cmd_data;
      end
      if (w_issue) begin
        r_rsp_err  <= w_refuse;
        r_rsp_data <= w_rsp_data;
      end
      // Saturate at the ends; the stack itself still shifts on a full push.
      if (w_push) begin
        if (depth != C_FULL) depth <= depth + DW'(1);
      end else if (w_pop) begin
        if (depth != '0) depth <= depth - DW'(1);
      end
      ovf <= (w_push && (depth == C_FULL)) || (ovf && !flag_clr);
      unf <= (w_pop  && (depth == '0))     || (unf && !flag_clr);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_dbg_arbiter.sv
`default_nettype none
// Bench for stack_dbg_arbiter: a behavioural stack fixture on st_*, and a
// queue-based model of stack contents, occupancy and sticky flags.
module tb_stack_dbg_arbiter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 18;
  localparam int CAP   = DEPTH + 1;
  localparam int DW    = $clog2(CAP + 1);
  localparam logic [1:0] PEEK = 2'b00, PUSH = 2'b01, DEP = 2'b10, POP = 2'b11;

  logic             clk = 1'b0;
  logic             resetq = 1'b1;
  logic             core_we;
  logic [1:0]       core_delta;
  logic [WIDTH-1:0] core_wd;
  logic             st_we;
  logic [1:0]       st_delta;
  logic [WIDTH-1:0] st_wd;
  logic [WIDTH-1:0] st_rd;
  logic             halt;
  logic [DW-1:0]    depth;
  logic             ovf, unf, flag_clr;

  stack_dbg_arbiter_if #(.WIDTH(WIDTH)) dbg ();

  stack_dbg_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetq(resetq), .core_we(core_we), .core_delta(core_delta),
    .core_wd(core_wd), .st_we(st_we), .st_delta(st_delta), .st_wd(st_wd),
    .st_rd(st_rd), .halt(halt), .dbg(dbg), .depth(depth), .ovf(ovf),
    .unf(unf), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  // Stack fixture: top register plus DEPTH-entry tail, driven only by st_*.
  logic [WIDTH-1:0] fx_top;
  logic [WIDTH-1:0] fx_tail [DEPTH];
  assign st_rd = fx_top;

  always @(posedge clk) begin
    if (st_delta == 2'b01) begin
      for (int i = DEPTH - 1; i > 0; i--) fx_tail[i] <= fx_tail[i-1];
      fx_tail[0] <= fx_top;
      if (st_we) fx_top <= st_wd;
    end else if (st_delta == 2'b11) begin
      fx_top <= fx_tail[0];
      for (int i = 0; i < DEPTH - 1; i++) fx_tail[i] <= fx_tail[i+1];
    end else if (st_we) begin
      fx_top <= st_wd;
    end
  end

  // Reference model: m_q[0] is the top of stack, size is the occupancy.
  logic [WIDTH-1:0] m_q [$];
  bit               m_ovf, m_unf;
  int               n_pass, n_total;

  task automatic model_core(input logic we, input logic [1:0] dl, input logic [WIDTH-1:0] wd);
    if (dl == 2'b01) begin
      m_q.push_front(wd);
      if (m_q.size() > CAP) begin
        void'(m_q.pop_back());
        m_ovf = 1'b1;
      end
    end else if (dl == 2'b11) begin
      if (m_q.size() == 0) m_unf = 1'b1;
      else void'(m_q.pop_front());
    end else if (we && m_q.size() > 0) begin
      m_q[0] = wd;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // kind: 0 idle, 1 push, 2 pop, 3 write top
  task automatic drive_core(input int kind, input logic [WIDTH-1:0] wd);
    core_we = 1'b0; core_delta = 2'b00; core_wd = '0;
    case (kind)
      1: begin core_we = 1'b1; core_delta = 2'b01; core_wd = wd; end
      2: core_delta = 2'b11;
      3: begin core_we = 1'b1; core_wd = wd; end
      default: ;
    endcase
  endtask

  task automatic core_cycle(input int kind, input logic [WIDTH-1:0] wd, input logic clr);
    drive_core(kind, wd);
    flag_clr = clr;
    #1;
    n_total++;
    if ({st_we, st_delta, st_wd} !== {core_we, core_delta, core_wd})
      $display("FAIL core_mirror: st=%b/%b/%h want %b/%b/%h", st_we, st_delta, st_wd,
               core_we, core_delta, core_wd);
    else n_pass++;
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    model_core(core_we, core_delta, core_wd);
    tick();
    drive_core(0, '0);
    flag_clr = 1'b0;
    n_total++;
    if ({depth, ovf, unf} !== {DW'(m_q.size()), m_ovf, m_unf})
      $display("FAIL core_state: depth/ovf/unf=%0d/%b/%b want %0d/%b/%b", depth, ovf, unf,
               m_q.size(), m_ovf, m_unf);
    else n_pass++;
  endtask

  // One debug transaction: accept, `busy` core-active cycles, issue, response
  // held `hold` cycles, then handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input int busy, input int hold);
    logic             refuse, e_we;
    logic [1:0]       e_dl;
    logic [WIDTH-1:0] e_wd, e_rsp;
    int               kind;
    dbg.cmd_valid = 1'b1; dbg.cmd_op = op; dbg.cmd_data = data;
    drive_core(0, '0);
    #1;
    n_total++;
    if ({dbg.cmd_ready, halt, dbg.rsp_valid} !== 3'b100)
      $display("FAIL accept: ready/halt/rsp_valid=%b%b%b want 100", dbg.cmd_ready, halt, dbg.rsp_valid);
    else n_pass++;
    tick();
    dbg.cmd_valid = 1'b0; dbg.cmd_data = '0;
    for (int k = 0; k < busy; k++) begin
      kind = (m_q.size() == 0) ? 1 : int'($urandom_range(1, 3));
      drive_core(kind, WIDTH'($urandom));
      #1;
      n_total++;
      if ({halt, st_we, st_delta, st_wd} !== {1'b1, core_we, core_delta, core_wd})
        $display("FAIL busy_mirror: halt=%b st=%b/%b/%h want 1 %b/%b/%h", halt, st_we, st_delta,
                 st_wd, core_we, core_delta, core_wd);
      else n_pass++;
      model_core(core_we, core_delta, core_wd);
      tick();
    end
    drive_core(0, '0);
    #1;
    refuse = (op == PUSH && m_q.size() == CAP) || (op == POP && m_q.size() == 0);
    e_we = 1'b0; e_dl = 2'b00; e_wd = '0; e_rsp = '0;
    if (!refuse) begin
      case (op)
        PUSH: begin e_we = 1'b1; e_dl = 2'b01; e_wd = data; e_rsp = data; end
        POP:  begin e_dl = 2'b11; e_rsp = m_q[0]; end
        DEP:  e_rsp = WIDTH'(m_q.size());
        default: e_rsp = (m_q.size() > 0) ? m_q[0] : fx_top;
      endcase
    end
    n_total++;
    if ({halt, st_we, st_delta, st_wd} !== {1'b1, e_we, e_dl, e_wd})
      $display("FAIL issue: halt=%b st=%b/%b/%h want 1 %b/%b/%h", halt, st_we, st_delta, st_wd,
               e_we, e_dl, e_wd);
    else n_pass++;
    if (!refuse) model_core(e_we, e_dl, e_wd);
    tick();
    for (int k = 0; k <= hold; k++) begin
      n_total++;
      if ({dbg.rsp_valid, dbg.rsp_err, dbg.rsp_data, halt, dbg.cmd_ready} !== {1'b1, refuse, e_rsp, 2'b00})
        $display("FAIL response: valid/err/data/halt/ready=%b/%b/%h/%b/%b want 1/%b/%h/0/0",
                 dbg.rsp_valid, dbg.rsp_err, dbg.rsp_data, halt, dbg.cmd_ready, refuse, e_rsp);
      else n_pass++;
      if (k < hold) tick();
    end
    dbg.rsp_ready = 1'b1;
    tick();
    dbg.rsp_ready = 1'b0;
    n_total++;
    if ({dbg.rsp_valid, dbg.cmd_ready, depth, ovf, unf} !== {2'b01, DW'(m_q.size()), m_ovf, m_unf})
      $display("FAIL after_rsp: valid/ready=%b%b depth=%0d ovf/unf=%b%b want 01 %0d %b%b",
               dbg.rsp_valid, dbg.cmd_ready, depth, ovf, unf, m_q.size(), m_ovf, m_unf);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2 resetq = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if ({halt, dbg.rsp_valid, dbg.rsp_err, ovf, unf, depth, dbg.rsp_data, dbg.cmd_ready} !==
        {5'b0, DW'(0), WIDTH'(0), 1'b1})
      $display("FAIL reset: halt/valid/err/ovf/unf=%b%b%b%b%b depth=%0d data=%h ready=%b", halt,
               dbg.rsp_valid, dbg.rsp_err, ovf, unf, depth, dbg.rsp_data, dbg.cmd_ready);
    else n_pass++;
    resetq = 1'b1;
    model_reset();
    tick();
    n_total++;
    if ({st_we, st_delta, st_wd, dbg.cmd_ready} !== {3'b000, WIDTH'(0), 1'b1})
      $display("FAIL reset_idle: st=%b/%b/%h ready=%b want 0/00/0000/1", st_we, st_delta, st_wd,
               dbg.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_core_push();
    core_cycle(1, 16'h1111, 1'b0);
    core_cycle(1, 16'h2222, 1'b0);
    run_cmd(DEP, '0, 0, 0);
  endtask

  task automatic test_dbg_push_pop();
    run_cmd(PUSH, 16'hBEEF, 0, 1);
    run_cmd(PEEK, '0, 0, 0);
    run_cmd(POP, '0, 0, 2);
    run_cmd(DEP, '0, 0, 0);
  endtask

  task automatic test_defer();
    run_cmd(PUSH, 16'h5A5A, 5, 0);
    run_cmd(POP, '0, 5, 0);
  endtask

  task automatic test_full();
    while (m_q.size() < CAP) core_cycle(1, WIDTH'($urandom), 1'b0);
    run_cmd(PUSH, 16'hDEAD, 0, 0);
    core_cycle(1, 16'h7777, 1'b0);
    core_cycle(0, '0, 1'b1);
    core_cycle(1, 16'h8888, 1'b1);
    core_cycle(0, '0, 1'b1);
    run_cmd(POP, '0, 0, 0);
    run_cmd(POP, '0, 0, 0);
  endtask

  task automatic test_empty();
    while (m_q.size() > 0) core_cycle(2, '0, 1'b0);
    run_cmd(POP, '0, 0, 0);
    core_cycle(2, '0, 1'b0);
    core_cycle(0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    dbg.cmd_valid = 1'b1; dbg.cmd_op = PEEK; dbg.cmd_data = '0;
    tick();
    dbg.cmd_valid = 1'b0;
    drive_core(1, 16'h4444);
    resetq = 1'b0;
    #1;
    n_total++;
    if ({halt, dbg.rsp_valid, dbg.cmd_ready, depth} !== {3'b001, DW'(0)})
      $display("FAIL reset_wait: halt/valid/ready=%b%b%b depth=%0d want 001 0", halt,
               dbg.rsp_valid, dbg.cmd_ready, depth);
    else n_pass++;
    drive_core(0, '0);
    resetq = 1'b1;
    model_reset();
    tick();
    n_total++;
    if ({dbg.cmd_ready, halt} !== 2'b10)
      $display("FAIL release_wait: ready/halt=%b%b want 10", dbg.cmd_ready, halt);
    else n_pass++;
    dbg.cmd_valid = 1'b1; dbg.cmd_op = PUSH; dbg.cmd_data = 16'hA5A5;
    tick();
    dbg.cmd_valid = 1'b0;
    tick();
    tick();
    n_total++;
    if ({dbg.rsp_valid, dbg.rsp_data} !== {1'b1, 16'hA5A5})
      $display("FAIL pre_reset_rsp: valid=%b data=%h want 1 a5a5", dbg.rsp_valid, dbg.rsp_data);
    else n_pass++;
    resetq = 1'b0;
    #1;
    n_total++;
    if ({dbg.rsp_valid, dbg.rsp_err, dbg.rsp_data, depth, ovf, unf} !== {2'b00, WIDTH'(0), DW'(0), 2'b00})
      $display("FAIL reset_resp: valid/err=%b%b data=%h depth=%0d ovf/unf=%b%b", dbg.rsp_valid,
               dbg.rsp_err, dbg.rsp_data, depth, ovf, unf);
    else n_pass++;
    resetq = 1'b1;
    model_reset();
    tick();
    n_total++;
    if ({dbg.cmd_ready, dbg.rsp_valid, halt} !== 3'b100)
      $display("FAIL release_resp: ready/valid/halt=%b%b%b want 100", dbg.cmd_ready,
               dbg.rsp_valid, halt);
    else n_pass++;
  endtask

  task automatic test_random();
    int kind;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) begin
          kind = (m_q.size() == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
          core_cycle(kind, WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
      end else begin
        run_cmd(2'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0;
    for (int i = 0; i < DEPTH; i++) fx_tail[i] = '0;
    fx_top = '0;
    drive_core(0, '0);
    flag_clr = 1'b0;
    dbg.cmd_valid = 1'b0; dbg.cmd_op = 2'b00; dbg.cmd_data = '0; dbg.rsp_ready = 1'b0;
    model_reset();
    test_reset();
    test_core_push();
    test_dbg_push_pop();
    test_defer();
    test_full();
    test_empty();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
